// File: rtl/draw_health_bar_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : draw_health_bar_pkg                                       |
// | Purpose  : Shared sprite geometry, colour keys and blink FSM states  |
// |            for the health-bar overlay.                               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package draw_health_bar_pkg;

   // Heart sprite geometry (pixels)
   localparam int HEART_W = 16;
   localparam int HEART_H = 16;

   // Colour that marks a see-through sprite pixel
   localparam logic [11:0] HEART_TRANSPARENT = 12'h6DE;

   // Empty-heart sprite sits directly below the full one in heart_mem
   localparam int EMPTY_ROW_OFS = 16;

   // Body colours used by the sprite ROM
   localparam logic [11:0] HEART_FULL_RGB  = 12'hE22;
   localparam logic [11:0] HEART_EMPTY_RGB = 12'h555;

   // Lost-heart blink controller states
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BLINK = 1'b1
   } hb_state_t;

endpackage
`default_nettype wire

// File: rtl/heart_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : heart_mem                                                 |
// | Purpose  : 16x32 RGB444 heart sprite ROM, rows 0..15 full heart,     |
// |            rows 16..31 empty heart; synchronous 1-cycle read.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module heart_mem
   import draw_health_bar_pkg::*;
(
   input  logic        clk,
   input  logic [4:0]  row,
   input  logic [3:0]  col,
   output logic [11:0] color_data
);

   logic [3:0]  w_r;
   logic        w_empty;
   logic        w_opaque;
   logic [11:0] w_pix;
   logic [11:0] color_q;

   assign w_r     = row[3:0];
   assign w_empty = row[4];

   // Heart silhouette: a box with a notch at the top centre and cut bottom corners
   always_comb begin
      w_opaque = 1'b0;
      if ((w_r >= 4'd2) && (w_r <= 4'd13) && (col >= 4'd1) && (col <= 4'd14)) begin
         w_opaque = 1'b1;
         if ((w_r <= 4'd3) && ((col == 4'd7) || (col == 4'd8))) begin
            w_opaque = 1'b0;
         end
         if ((w_r >= 4'd12) && ((col <= 4'd3) || (col >= 4'd12))) begin
            w_opaque = 1'b0;
         end
      end
      if (!w_opaque) begin
         w_pix = HEART_TRANSPARENT;
      end else if (w_empty) begin
         w_pix = HEART_EMPTY_RGB;
      end else begin
         w_pix = HEART_FULL_RGB;
      end
   end

   // Synchronous read port
   always_ff @(posedge clk) begin
      color_q <= w_pix;
   end

   assign color_data = color_q;

endmodule
`default_nettype wire

// File: rtl/draw_health_bar.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : draw_health_bar                                           |
// | Purpose  : Overlays MAX_HEARTS heart sprites showing hp; lost hearts |
// |            blink for a while when DRAW_HEALTH_BLINK_EN is defined.   |
// |            Outputs are valid two clocks after x/y.                   |
// | Config   : DRAW_HEALTH_BLINK_EN - enables the lost-heart blink FSM   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module draw_health_bar
   import draw_health_bar_pkg::*;
#(
   parameter int MAX_HEARTS   = 3,
   parameter int X0           = 240,
   parameter int Y0           = 16,
   parameter int HP_W         = 4,
   parameter int BLINK_FRAMES = 32,
   parameter int BLINK_PERIOD = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [9:0]      x,
   input  logic [9:0]      y,
   input  logic            frame_tick,
   input  logic [HP_W-1:0] hp,
   output logic [11:0]     color_data,
   output logic            hearts_on
);

   localparam logic [10:0] X_LO   = 11'(X0);
   localparam logic [10:0] X_HI   = 11'(X0 + HEART_W * MAX_HEARTS);
   localparam logic [10:0] Y_LO   = 11'(Y0);
   localparam logic [10:0] Y_HI   = 11'(Y0 + HEART_H);
   localparam logic [3:0]  HP_MAX = 4'(MAX_HEARTS);

   logic [3:0] w_hp_clamped;
   logic [3:0] hp_disp_q;
   logic       w_blink_on;
   logic [3:0] w_blink_lo;
   logic [3:0] w_blink_hi;

   // Limit incoming health to the number of drawable slots
   always_comb begin
      w_hp_clamped = 4'(hp);
      if (hp > HP_W'(MAX_HEARTS)) begin
         w_hp_clamped = HP_MAX;
      end
   end

`ifdef DRAW_HEALTH_BLINK_EN
   localparam logic [7:0] FRAMES_END = 8'(BLINK_FRAMES);
   localparam logic [7:0] PERIOD_END = 8'(BLINK_PERIOD);

   hb_state_t  state_q,     state_d;
   logic [3:0] hp_disp_d;
   logic [3:0] blink_lo_q,  blink_lo_d;
   logic [3:0] blink_hi_q,  blink_hi_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic [7:0] phase_cnt_q, phase_cnt_d;
   logic       phase_on_q,  phase_on_d;

   // Blink controller state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         hp_disp_q   <= HP_MAX;
         blink_lo_q  <= '0;
         blink_hi_q  <= '0;
         frame_cnt_q <= '0;
         phase_cnt_q <= '0;
         phase_on_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         hp_disp_q   <= hp_disp_d;
         blink_lo_q  <= blink_lo_d;
         blink_hi_q  <= blink_hi_d;
         frame_cnt_q <= frame_cnt_d;
         phase_cnt_q <= phase_cnt_d;
         phase_on_q  <= phase_on_d;
      end
   end

   // Next-state: start, extend, age or abort a blink once per frame
   always_comb begin
      state_d     = state_q;
      hp_disp_d   = hp_disp_q;
      blink_lo_d  = blink_lo_q;
      blink_hi_d  = blink_hi_q;
      frame_cnt_d = frame_cnt_q;
      phase_cnt_d = phase_cnt_q;
      phase_on_d  = phase_on_q;
      if (frame_tick) begin
         hp_disp_d = w_hp_clamped;
         case (state_q)
            ST_IDLE: begin
               if (w_hp_clamped < hp_disp_q) begin
                  state_d     = ST_BLINK;
                  blink_lo_d  = w_hp_clamped;
                  blink_hi_d  = hp_disp_q;
                  frame_cnt_d = '0;
                  phase_cnt_d = '0;
                  phase_on_d  = 1'b1;
               end
            end
            ST_BLINK: begin
               if (w_hp_clamped < hp_disp_q) begin
                  // Further loss widens the range downward and restarts timing
                  blink_lo_d  = w_hp_clamped;
                  frame_cnt_d = '0;
                  phase_cnt_d = '0;
                  phase_on_d  = 1'b1;
               end else if ((w_hp_clamped > hp_disp_q) || (w_hp_clamped == blink_hi_q)) begin
                  // Healing cancels the blink immediately
                  state_d     = ST_IDLE;
                  frame_cnt_d = '0;
                  phase_cnt_d = '0;
                  phase_on_d  = 1'b1;
               end else begin
                  frame_cnt_d = frame_cnt_q + 8'd1;
                  if (frame_cnt_d == FRAMES_END) begin
                     state_d     = ST_IDLE;
                     frame_cnt_d = '0;
                     phase_cnt_d = '0;
                     phase_on_d  = 1'b1;
                  end else begin
                     phase_cnt_d = phase_cnt_q + 8'd1;
                     if (phase_cnt_d == PERIOD_END) begin
                        phase_cnt_d = '0;
                        phase_on_d  = ~phase_on_q;
                     end
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign w_blink_on = (state_q == ST_BLINK) && phase_on_q;
   assign w_blink_lo = blink_lo_q;
   assign w_blink_hi = blink_hi_q;
`else
   // Displayed health follows hp directly, once per frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hp_disp_q <= HP_MAX;
      end else if (frame_tick) begin
         hp_disp_q <= w_hp_clamped;
      end
   end

   assign w_blink_on = 1'b0;
   assign w_blink_lo = '0;
   assign w_blink_hi = '0;
`endif

   // ---------------- stage 1: slot decode and sprite addressing ----------
   logic       w_in_slot;
   logic [6:0] w_dx;
   logic [3:0] w_dy;
   logic [2:0] w_slot;
   logic       w_full;
   logic [4:0] w_row;
   logic [4:0] row_q;
   logic [3:0] col_q;
   logic       in_slot_q;
   logic       in_slot2_q;
   logic [11:0] w_mem_color;

   assign w_in_slot = ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI) &&
                      ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);
   assign w_dx   = 7'({1'b0, x} - X_LO);
   assign w_dy   = 4'({1'b0, y} - Y_LO);
   assign w_slot = w_dx[6:4];

   // Full sprite for hearts still held, or for lost hearts during blink-on
   always_comb begin
      w_full = ({1'b0, w_slot} < hp_disp_q);
      if (w_blink_on && ({1'b0, w_slot} >= w_blink_lo) && ({1'b0, w_slot} < w_blink_hi)) begin
         w_full = 1'b1;
      end
      w_row = w_full ? {1'b0, w_dy} : (5'(EMPTY_ROW_OFS) + {1'b0, w_dy});
   end

   // Stage-1 address and in-slot registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q     <= '0;
         col_q     <= '0;
         in_slot_q <= 1'b0;
      end else begin
         row_q     <= w_row;
         col_q     <= w_dx[3:0];
         in_slot_q <= w_in_slot;
      end
   end

   // ---------------- stage 2: sprite read, aligned in-slot flag ----------
   heart_mem u_heart_mem (
      .clk        (clk),
      .row        (row_q),
      .col        (col_q),
      .color_data (w_mem_color)
   );

   // Delay the in-slot flag to line up with the ROM data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_slot2_q <= 1'b0;
      end else begin
         in_slot2_q <= in_slot_q;
      end
   end

   assign color_data = w_mem_color;
   assign hearts_on  = in_slot2_q && (w_mem_color != HEART_TRANSPARENT);

endmodule
`default_nettype wire
